// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V definitions: data width, major opcodes,
//                branch prediction payload, branch-resolve FSM states and
//                conditional-branch funct3 encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instruction[6:0])
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    // Prediction made at fetch, carried down the pipe with the instruction
    typedef struct packed {
        logic            predict_taken;
        logic [XLEN-1:0] predict_target;
    } branch_pred_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } branch_resolve_state_e;

    // Conditional branch funct3 encodings; 3'b010 and 3'b011 are reserved
    localparam logic [2:0] c_FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] c_FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] c_FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] c_FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] c_FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] c_FUNCT3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/branch_compare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_compare
//  Description : Combinational condition evaluator for conditional branches.
//  Ports       : rs1, rs2      - operands
//                funct3        - branch condition select
//                taken         - condition holds
//                valid_funct3  - funct3 names a defined branch condition
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_compare
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            valid_funct3
);

    always_comb begin
        taken        = 1'b0;
        valid_funct3 = 1'b1;
        case (funct3)
            c_FUNCT3_BEQ:  taken = (rs1 == rs2);
            c_FUNCT3_BNE:  taken = (rs1 != rs2);
            c_FUNCT3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            c_FUNCT3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            c_FUNCT3_BLTU: taken = (rs1 <  rs2);
            c_FUNCT3_BGEU: taken = (rs1 >= rs2);
            default: begin
                taken        = 1'b0;
                valid_funct3 = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Resolves conditional branches and jumps in EX, checks them
//                against the fetch-time prediction, trains the predictor/BTB
//                and holds a fetch redirect until IF accepts it.
//  Ports       : clk, reset_n           - clock, async active-low reset
//                ex_valid/ex_ready      - instruction handshake from EX
//                ex_pc, ex_instruction  - PC and raw instruction word
//                ex_rs1_data/rs2_data   - forwarded operands
//                ex_pred                - prediction from IF
//                redirect_*             - fetch redirect handshake
//                update_*, is_branch,
//                actual_*               - predictor training pulse
//                btb_wr_*               - BTB fill
//                perf_*                 - saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              reset_n,
    // EX handshake
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_instruction,
    input  logic [XLEN-1:0]   ex_rs1_data,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  branch_pred_t      ex_pred,
    // Fetch redirect
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              redirect_ready,
    // Predictor training
    output logic              update_en,
    output logic              is_branch,
    output logic              actual_taken,
    output logic [XLEN-1:0]   update_pc,
    output logic [XLEN-1:0]   actual_target,
    // BTB fill
    output logic              btb_wr_en,
    output logic [XLEN-1:0]   btb_wr_pc,
    output logic [XLEN-1:0]   btb_wr_target,
    // Performance counters
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    opcode_e         w_opcode;
    logic [2:0]      w_funct3;
    logic            w_cmp_taken;
    logic            w_cmp_valid;
    logic            w_is_cond;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_ctrl;

    assign w_opcode  = opcode_e'(ex_instruction[6:0]);
    assign w_funct3  = ex_instruction[14:12];

    branch_compare #(
        .XLEN         (XLEN)
    ) u_branch_compare (
        .rs1          (ex_rs1_data),
        .rs2          (ex_rs2_data),
        .funct3       (w_funct3),
        .taken        (w_cmp_taken),
        .valid_funct3 (w_cmp_valid)
    );

    // A reserved funct3 under OP_BRANCH is not a control transfer at all
    assign w_is_cond = (w_opcode == OP_BRANCH) && w_cmp_valid;
    assign w_is_jal  = (w_opcode == OP_JAL);
    assign w_is_jalr = (w_opcode == OP_JALR);
    assign w_is_ctrl = w_is_cond || w_is_jal || w_is_jalr;

    // ------------------------------------------------------------------
    // Immediates and target computation (all wrap modulo 2^XLEN)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_jal_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_target;
    logic            w_taken;
    logic [XLEN-1:0] w_next_pc;

    assign w_imm_b = {{(XLEN-13){ex_instruction[31]}}, ex_instruction[31],
                      ex_instruction[7], ex_instruction[30:25],
                      ex_instruction[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-21){ex_instruction[31]}}, ex_instruction[31],
                      ex_instruction[19:12], ex_instruction[20],
                      ex_instruction[30:21], 1'b0};
    assign w_imm_i = {{(XLEN-12){ex_instruction[31]}}, ex_instruction[31:20]};

    assign w_pc_plus4      = ex_pc + XLEN'(4);
    assign w_branch_target = ex_pc + w_imm_b;
    assign w_jal_target    = ex_pc + w_imm_j;
    assign w_jalr_sum      = ex_rs1_data + w_imm_i;
    assign w_jalr_target   = w_jalr_sum & ~XLEN'(1);

    assign w_taken = w_is_jal || w_is_jalr || (w_is_cond && w_cmp_taken);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_jal) begin
            w_next_pc = w_jal_target;
        end else if (w_is_jalr) begin
            w_next_pc = w_jalr_target;
        end else if (w_is_cond && w_cmp_taken) begin
            w_next_pc = w_branch_target;
        end
    end

    // ------------------------------------------------------------------
    // Prediction check
    // ------------------------------------------------------------------
    logic w_target_miss;
    logic w_mispredict;
    logic w_btb_wr;
    logic w_fire;
    logic w_update;
    logic w_redirect_start;

    // The target only matters when both prediction and outcome are taken.
    // A non-control op predicted taken falls out of the direction term and
    // is redirected to pc+4.
    assign w_target_miss    = (ex_pred.predict_target != w_next_pc);
    assign w_mispredict     = (ex_pred.predict_taken != w_taken) ||
                              (ex_pred.predict_taken && w_taken && w_target_miss);
    assign w_btb_wr         = w_is_ctrl && w_taken &&
                              (!ex_pred.predict_taken || w_target_miss);

    assign w_fire           = ex_valid && ex_ready;
    assign w_update         = w_fire && w_is_ctrl;
    assign w_redirect_start = w_fire && w_mispredict;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    branch_resolve_state_e r_state;
    branch_resolve_state_e w_state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs decode straight from the state register, so they stay glitch
    // free and change only on clock edges. While REDIRECT is held, EX is
    // stalled so the younger (squashed) op is never accepted.
    always_comb begin
        w_state_next   = r_state;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            IDLE: begin
                ex_ready = 1'b1;
                if (w_redirect_start) begin
                    w_state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered result outputs
    // ------------------------------------------------------------------
    logic            r_update_en;
    logic            r_is_branch;
    logic            r_actual_taken;
    logic [XLEN-1:0] r_update_pc;
    logic [XLEN-1:0] r_actual_target;
    logic            r_btb_wr_en;
    logic [XLEN-1:0] r_btb_wr_pc;
    logic [XLEN-1:0] r_btb_wr_target;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_perf_branches;
    logic [31:0]     r_perf_mispredicts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_update_en     <= 1'b0;
            r_is_branch     <= 1'b0;
            r_actual_taken  <= 1'b0;
            r_update_pc     <= '0;
            r_actual_target <= '0;
        end else begin
            r_update_en <= w_update;
            if (w_update) begin
                r_is_branch     <= w_is_cond;
                r_actual_taken  <= w_taken;
                r_update_pc     <= ex_pc;
                r_actual_target <= w_next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btb_wr_en     <= 1'b0;
            r_btb_wr_pc     <= '0;
            r_btb_wr_target <= '0;
        end else begin
            r_btb_wr_en <= w_fire && w_btb_wr;
            if (w_fire && w_btb_wr) begin
                r_btb_wr_pc     <= ex_pc;
                r_btb_wr_target <= w_next_pc;
            end
        end
    end

    // Captured only on entry to REDIRECT, so it is stable for the whole
    // time redirect_valid is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_pc <= '0;
        end else if (w_redirect_start) begin
            r_redirect_pc <= w_next_pc;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            if (w_update && (r_perf_branches != 32'hFFFF_FFFF)) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_redirect_start && (r_perf_mispredicts != 32'hFFFF_FFFF)) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign update_en        = r_update_en;
    assign is_branch        = r_is_branch;
    assign actual_taken     = r_actual_taken;
    assign update_pc        = r_update_pc;
    assign actual_target    = r_actual_target;
    assign btb_wr_en        = r_btb_wr_en;
    assign btb_wr_pc        = r_btb_wr_pc;
    assign btb_wr_target    = r_btb_wr_target;
    assign redirect_pc      = r_redirect_pc;
    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule
`default_nettype wire
